vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

Raster scan generator that drives the pixel coordinates consumed by the color mapper and the sync/blank pins of the VGA DAC. It divides the 50 MHz system clock to a 25 MHz pixel clock and runs horizontal and vertical counters for 640x480 @ 60 Hz. It emits DrawX/DrawY each pixel, along with active-low syncs, blanking, and a once-per-frame tick for game-logic updates.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- Clk  in  1  50 MHz system clock; the single clock
- Reset  in  1  asynchronous, active-high
- VGA_CLK  out  1  pixel clock, Clk/2
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high only inside the visible region
- VGA_SYNC_N  out  1  constant 0
- DrawX  out  10  horizontal count, 0..H_TOTAL-1
- DrawY  out  10  vertical count, 0..V_TOTAL-1
- frame_start  out  1  one-Clk pulse at the start of each frame

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL (525). All counter arithmetic is unsigned 10-bit.
- Phase: VGA_CLK is a register toggling every Clk. The pixel enable pix_ce = VGA_CLK. Counters advance only on edges where pix_ce=1.
- hc: 0 → H_TOTAL-1, then wraps to 0. On the hc wrap, vc increments; vc wraps from V_TOTAL-1 to 0.
- DrawX = hc, DrawY = vc. Both keep counting through blanking.
- VGA_HS = 0 iff H_VISIBLE+H_FP ≤ hc < H_VISIBLE+H_FP+H_SYNC (656..751).
- VGA_VS = 0 iff V_VISIBLE+V_FP ≤ vc < V_VISIBLE+V_FP+V_SYNC (490..491).
- VGA_BLANK_N = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
- HS/VS/BLANK_N are registered from the next-state counter values, so they stay aligned with DrawX/DrawY with no combinational glitches.
- frame_start asserts for exactly one Clk, on the edge where the counters wrap from (799,524) to (0,0).
- Implicit scan states: ACTIVE, H_FRONT, H_SYNC, H_BACK on hc; the same four on vc. They are decoded from counters, not an explicit FSM.

## Timing
- Reset values: VGA_CLK=0, hc=vc=0, DrawX=DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_start=0, VGA_SYNC_N=0.
- After Reset falls, VGA_BLANK_N goes 1 on the first pix_ce edge with (0,0) still held. The first counter increment comes on the following pix_ce edge.
- One pixel lasts 2 Clk. One line lasts 1600 Clk. One frame lasts 840000 Clk.
- Reset asserted mid-frame clears everything immediately, without waiting for a clock. The restart is identical to power-up. No partial frame_start is emitted.
- A simultaneous h and v wrap produces a single frame_start, not two events.

## Configuration
- SCAN_SYNC_DELAY_EN defined: VGA_HS, VGA_VS and VGA_BLANK_N pass through one additional pix_ce-qualified register stage. They lag DrawX/DrawY by exactly one pixel (2 Clk), which matches a color mapper with one registered RGB stage. Reset value of the stage is HS=1, VS=1, BLANK_N=0.
- Not defined: syncs and blank are aligned with DrawX/DrawY as described above. frame_start is never delayed in either build.

## Structure
- Package vga_scan_pkg holds:
  - the default timing constants;
  - derived H_TOTAL, V_TOTAL, H_SYNC_START/END and V_SYNC_START/END localparams;
  - a 10-bit coord_t typedef, shared with the color mapper.
- Sub-module vga_sync_delay (3-bit, pix_ce-enabled, async-reset register) is instantiated only under SCAN_SYNC_DELAY_EN.

## Test plan
- Reset asserted, then released → all outputs hold their reset values. VGA_CLK toggles every Clk. DrawX reaches 1 after 4 Clk.
- Run one line → DrawX goes 799→0 and DrawY goes 0→1 on the same edge. VGA_BLANK_N falls when DrawX=640.
- Horizontal sync → VGA_HS stays low for exactly 192 Clk, covering DrawX 656..751, on every line.
- Run a full frame → VGA_VS low only while DrawY is 490..491. frame_start pulses are 840000 Clk apart, each 1 Clk wide, coinciding with (0,0).
- Reset pulsed at DrawX=300, DrawY=200 → immediate return to (0,0), VGA_HS=1, VGA_VS=1, no frame_start.
- Build with SCAN_SYNC_DELAY_EN → VGA_HS first falls 2 Clk after DrawX=656. VGA_BLANK_N falls 2 Clk after DrawX=640. Counter timing is unchanged.

Source files
------------

// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg: default 640x480@60 timing, derived line/frame constants,
// the shared screen-coordinate type and the counter-to-region decode.
package vga_scan_pkg;

  // Default horizontal timing, in pixels
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  // Default vertical timing, in lines
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  // Derived totals and sync windows (END is the first count past the pulse)
  localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  // Screen coordinate, shared with the color mapper
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Sync/blank side-band width and its idle value {HS, VS, BLANK_N}
  localparam int                    SYNC_DLY_W   = 3;
  localparam logic [SYNC_DLY_W-1:0] SYNC_DLY_RST = 3'b110;

  // Region of a line (on hc) or of a frame (on vc)
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } scan_state_t;

  // Classify a count against visible / front-porch / sync widths.
  // Anything past the sync pulse is back porch.
  function automatic scan_state_t scan_region(input coord_t c,
                                              input coord_t vis,
                                              input coord_t fp,
                                              input coord_t sync);
    scan_state_t st;
    if (c < vis) begin
      st = ST_ACTIVE;
    end else if (c < vis + fp) begin
      st = ST_FRONT;
    end else if (c < vis + fp + sync) begin
      st = ST_SYNC;
    end else begin
      st = ST_BACK;
    end
    return st;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: pixel-enabled register stage for the HS/VS/BLANK_N
// side-band, so it lines up with a color mapper that registers RGB once.
module vga_sync_delay
  import vga_scan_pkg::*;
#(
  parameter int              W       = SYNC_DLY_W,
  parameter logic [W-1:0]    RST_VAL = SYNC_DLY_RST
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Capture the side-band once per pixel; idle value on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (ce_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster scan generator. Divides Clk by two for the pixel
// clock, runs hc/vc, and produces DrawX/DrawY, active-low syncs, blanking
// and a one-Clk frame_start.
// Build option: SCAN_SYNC_DELAY_EN adds one pixel of delay on HS/VS/BLANK_N.
//
// Scan regions are decoded from the counters, not held in a state register:
//   region    | hc (pixels)   | vc (lines)
//   ACTIVE    | 0..639        | 0..479
//   H/V_FRONT | 640..655      | 480..489
//   H/V_SYNC  | 656..751      | 490..491
//   H/V_BACK  | 752..799      | 492..524
module vga_scan_gen
  import vga_scan_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               frame_start
);

  localparam coord_t HC_LAST = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t VC_LAST = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t H_FP_C   = coord_t'(H_FP);
  localparam coord_t H_SYNC_C = coord_t'(H_SYNC);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t V_FP_C   = coord_t'(V_FP);
  localparam coord_t V_SYNC_C = coord_t'(V_SYNC);

  logic        vga_clk_q;
  logic        pix_ce;
  logic        started_q;
  coord_t      hc_q, hc_d;
  coord_t      vc_q, vc_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        frame_q, frame_d;
  scan_state_t h_st, v_st;

  // The pixel enable is the divided clock itself: high on every other Clk
  assign pix_ce = vga_clk_q;

  // Next counter values, frame wrap detect and side-band decode of the
  // next position so syncs/blank stay aligned with DrawX/DrawY
  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    frame_d = 1'b0;

    // The first pixel slot after reset presents (0,0) without advancing
    if (pix_ce && started_q) begin
      if (hc_q == HC_LAST) begin
        hc_d = '0;
        if (vc_q == VC_LAST) begin
          vc_d    = '0;
          frame_d = 1'b1;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end

    h_st      = scan_region(hc_d, H_VIS_C, H_FP_C, H_SYNC_C);
    v_st      = scan_region(vc_d, V_VIS_C, V_FP_C, V_SYNC_C);
    hs_d      = (h_st != ST_SYNC);
    vs_d      = (v_st != ST_SYNC);
    blank_n_d = (h_st == ST_ACTIVE) && (v_st == ST_ACTIVE);
  end

  // Pixel clock divider, counters and registered side-band
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vga_clk_q <= 1'b0;
      started_q <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      vga_clk_q <= ~vga_clk_q;
      frame_q   <= frame_d;
      if (pix_ce) begin
        started_q <= 1'b1;
        hc_q      <= hc_d;
        vc_q      <= vc_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        blank_n_q <= blank_n_d;
      end
    end
  end

  assign VGA_CLK     = vga_clk_q;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_start = frame_q;

`ifdef SCAN_SYNC_DELAY_EN
  logic [SYNC_DLY_W-1:0] side_dly;

  vga_sync_delay #(
    .W       (SYNC_DLY_W),
    .RST_VAL (SYNC_DLY_RST)
  ) u_sync_delay (
    .clk_i (Clk),
    .rst_i (Reset),
    .ce_i  (pix_ce),
    .d_i   ({hs_q, vs_q, blank_n_q}),
    .q_o   (side_dly)
  );

  assign VGA_HS      = side_dly[2];
  assign VGA_VS      = side_dly[1];
  assign VGA_BLANK_N = side_dly[0];
`else
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: checks a default-timing instance over a few lines and a
// shrunken-timing instance over several whole frames against a closed-form
// model of position versus Clk edges since reset release.
module tb_vga_scan_gen;

  localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
  localparam int VV = 480, VF = 10, VSW = 2,  VB = 33;
  localparam int SHV = 8, SHF = 2, SHSW = 3, SHB = 3;
  localparam int SVV = 4, SVF = 1, SVSW = 2, SVB = 2;
  localparam int LIM = 3000;

`ifdef SCAN_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic       a_vclk, a_hs, a_vs, a_bn, a_sn, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_vclk, b_hs, b_vs, b_bn, b_sn, b_fs;
  logic [9:0] b_x, b_y;

  vga_scan_gen u_a (
    .Clk(clk), .Reset(rst_a), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .DrawX(a_x), .DrawY(a_y),
    .frame_start(a_fs)
  );

  vga_scan_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHSW), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVSW), .V_BP(SVB)
  ) u_b (
    .Clk(clk), .Reset(rst_b), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .DrawX(b_x), .DrawY(b_y),
    .frame_start(b_fs)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Clk edges seen since the last reset release, per instance
  int k_a = 0;
  int k_b = 0;
  always @(posedge clk or posedge rst_a) if (rst_a) k_a <= 0; else k_a <= k_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) k_b <= 0; else k_b <= k_b + 1;

  typedef struct {
    bit vclk; int x; int y; bit hs; bit vs; bit bn; bit fs;
  } exp_t;

  // Outputs after k edges: the divider toggles each edge, pixel slots fall
  // on even edges, the first slot only shows (0,0), each later slot moves
  // one pixel along the raster.
  function automatic exp_t model(input int k, input int hv, input int hf,
                                 input int hsw, input int hb, input int vv,
                                 input int vf, input int vsw, input int vb,
                                 input bit dly);
    exp_t e;
    int ht, vt, p, pl, px, py;
    bit valid;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = (k / 2 > 1) ? (k / 2 - 1) : 0;
    e.vclk = (k % 2) == 1;
    e.x    = p % ht;
    e.y    = (p / ht) % vt;
    e.fs   = (k % 2 == 0) && (k >= 4) && (p > 0) && (p % (ht * vt) == 0);
    e.hs   = 1'b1;
    e.vs   = 1'b1;
    e.bn   = 1'b0;
    if (dly) begin
      valid = (k >= 4);
      pl    = valid ? ((k - 2) / 2 - 1) : 0;
    end else begin
      valid = (k >= 2);
      pl    = p;
    end
    if (valid) begin
      px   = pl % ht;
      py   = (pl / ht) % vt;
      e.hs = !(px >= hv + hf && px < hv + hf + hsw);
      e.vs = !(py >= vv + vf && py < vv + vf + vsw);
      e.bn = (px < hv) && (py < vv);
    end
    return e;
  endfunction

  task automatic cmp(input string what, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", what, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input int k,
                            input int hv, input int hf, input int hsw, input int hb,
                            input int vv, input int vf, input int vsw, input int vb,
                            input logic vclk, input logic [9:0] x, input logic [9:0] y,
                            input logic hs, input logic vs, input logic bn,
                            input logic sn, input logic fs);
    exp_t e;
    e = model(k, hv, hf, hsw, hb, vv, vf, vsw, vb, DLY);
    cmp({nm, ".VGA_CLK"},     int'(vclk), int'(e.vclk));
    cmp({nm, ".DrawX"},       int'(x),    e.x);
    cmp({nm, ".DrawY"},       int'(y),    e.y);
    cmp({nm, ".VGA_HS"},      int'(hs),   int'(e.hs));
    cmp({nm, ".VGA_VS"},      int'(vs),   int'(e.vs));
    cmp({nm, ".VGA_BLANK_N"}, int'(bn),   int'(e.bn));
    cmp({nm, ".VGA_SYNC_N"},  int'(sn),   0);
    cmp({nm, ".frame_start"}, int'(fs),   int'(e.fs));
  endtask

  // Every cycle, both instances against the model
  always @(negedge clk) begin
    check_inst("a", k_a, HV, HF, HSW, HB, VV, VF, VSW, VB,
               a_vclk, a_x, a_y, a_hs, a_vs, a_bn, a_sn, a_fs);
    check_inst("b", k_b, SHV, SHF, SHSW, SHB, SVV, SVF, SVSW, SVB,
               b_vclk, b_x, b_y, b_hs, b_vs, b_bn, b_sn, b_fs);
  end

  task automatic wait_ax(input int target, input string nm);
    int cnt = 0;
    while (int'(a_x) != target && cnt < LIM) begin
      @(posedge clk); #1; cnt++;
    end
    cmp(nm, int'(a_x), target);
  endtask

  task automatic a_seq();
    int cnt;
    @(negedge clk);
    cmp("a_rst_x", a_x, 0);      cmp("a_rst_y", a_y, 0);
    cmp("a_rst_hs", a_hs, 1);    cmp("a_rst_vs", a_vs, 1);
    cmp("a_rst_bn", a_bn, 0);    cmp("a_rst_vclk", a_vclk, 0);
    cmp("a_rst_fs", a_fs, 0);    cmp("a_rst_syncn", a_sn, 0);
    rst_a = 1'b0;
    @(posedge clk); #1 cmp("a_vclk_e1", a_vclk, 1);
    @(posedge clk); #1 cmp("a_vclk_e2", a_vclk, 0);
    cmp("a_x_e2", a_x, 0);
    cmp("a_bn_e2", a_bn, DLY ? 0 : 1);
    @(posedge clk); #1 cmp("a_x_e3", a_x, 0);
    @(posedge clk); #1 cmp("a_x_e4", a_x, 1);
    // blanking at the end of the visible line
    wait_ax(640, "a_reach_x640");
    cmp("a_bn_at_x640", a_bn, DLY ? 1 : 0);
    repeat (2) @(posedge clk);
    #1 cmp("a_bn_x640_plus2", a_bn, 0);
    // line wrap
    wait_ax(799, "a_reach_x799");
    cmp("a_y_line0", a_y, 0);
    @(posedge clk); #1 cmp("a_x_hold799", a_x, 799);
    @(posedge clk); #1 cmp("a_x_wrap", a_x, 0);
    cmp("a_y_wrap", a_y, 1);
    // horizontal sync pulse on two lines
    for (int ln = 0; ln < 2; ln++) begin
      cnt = 0;
      while (a_hs !== 1'b0 && cnt < LIM) begin @(posedge clk); #1; cnt++; end
      cmp("a_hs_fall_x", a_x, 656 + int'(DLY));
      cnt = 0;
      do begin @(posedge clk); #1; cnt++; end while (a_hs === 1'b0 && cnt < LIM);
      cmp("a_hs_low_clks", cnt, 192);
      cmp("a_hs_rise_x", a_x, 752 + int'(DLY));
      cmp("a_hs_line_y", a_y, ln + 1);
    end
    // asynchronous reset mid-line
    wait_ax(300, "a_reach_x300");
    #2 rst_a = 1'b1;
    #1;
    cmp("a_mid_rst_x", a_x, 0);   cmp("a_mid_rst_y", a_y, 0);
    cmp("a_mid_rst_hs", a_hs, 1); cmp("a_mid_rst_vs", a_vs, 1);
    cmp("a_mid_rst_bn", a_bn, 0); cmp("a_mid_rst_fs", a_fs, 0);
    cmp("a_mid_rst_vclk", a_vclk, 0);
    @(posedge clk); #1 cmp("a_rst_hold_x", a_x, 0);
    @(negedge clk); rst_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 cmp("a_restart_x_e4", a_x, 1);
    repeat (50) @(posedge clk);
  endtask

  task automatic wait_bfs(output int cnt);
    cnt = 0;
    while (b_fs !== 1'b1 && cnt < LIM) begin @(posedge clk); #1; cnt++; end
  endtask

  task automatic b_seq();
    int cnt;
    @(negedge clk);
    rst_b = 1'b0;
    // 144-pixel frame = 288 Clk; first wrap after the holding slot
    wait_bfs(cnt);
    cmp("b_first_fs_clks", cnt, 290);
    cmp("b_fs_x", b_x, 0); cmp("b_fs_y", b_y, 0);
    for (int f = 0; f < 3; f++) begin
      @(posedge clk); #1 cmp("b_fs_width", b_fs, 0);
      wait_bfs(cnt);
      cmp("b_fs_period", cnt + 1, 288);
      cmp("b_fs_x", b_x, 0); cmp("b_fs_y", b_y, 0);
    end
    // reset while both syncs are low
    cnt = 0;
    while (!(b_vs === 1'b0 && b_hs === 1'b0) && cnt < LIM) begin
      @(posedge clk); #1; cnt++;
    end
    cmp("b_sync_y", b_y, 5);
    cmp("b_sync_x", b_x, 10 + int'(DLY));
    #2 rst_b = 1'b1;
    #1;
    cmp("b_mid_rst_x", b_x, 0);   cmp("b_mid_rst_y", b_y, 0);
    cmp("b_mid_rst_hs", b_hs, 1); cmp("b_mid_rst_vs", b_vs, 1);
    cmp("b_mid_rst_fs", b_fs, 0); cmp("b_mid_rst_bn", b_bn, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    wait_bfs(cnt);
    cmp("b_restart_fs_clks", cnt, 290);
    repeat (300) @(posedge clk);
  endtask

  initial begin
    fork
      a_seq();
      b_seq();
    join
    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
